// File: rtl/lb_pkg.sv
// Shared defaults and helpers for the multi-line pixel buffer.
package lb_pkg;

    // Ceiling log2, never below 1 so it can size a counter directly.
    function automatic int lb_clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    localparam int LB_WIDTH     = 8;
    localparam int LB_LINE_LEN  = 2000;
    localparam int LB_NUM_LINES = 4;
    localparam int LB_ADDR_W    = lb_clog2(LB_LINE_LEN);

endpackage

// File: rtl/lb_dp_ram.sv
// One line bank: single-clock dual-port RAM, read-first, read data held while re is low.
module lb_dp_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2000,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  dout
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] dout_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= din;
        end
    end

    // Read port; a same-address write in this cycle is not yet visible (read-first).
    always_ff @(posedge clk) begin
        if (re) begin
            dout_r <= mem_r[raddr];
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/line_buffer_2d.sv
// Line buffer: stores the last NUM_LINES lines and emits one padded vertical column per pixel.
module line_buffer_2d
    import lb_pkg::*;
#(
    parameter int WIDTH     = LB_WIDTH,
    parameter int LINE_LEN  = LB_LINE_LEN,
    parameter int NUM_LINES = LB_NUM_LINES,
    parameter int ADDR_W    = LB_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [WIDTH-1:0]               s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [(NUM_LINES+1)*WIDTH-1:0] m_data,
    output logic [ADDR_W-1:0]              m_col,
    output logic                           m_last,
    output logic                           m_rows_ok,
    output logic                           len_err
);

    localparam int                ROW_W     = lb_clog2(NUM_LINES + 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(LINE_LEN - 1);
    localparam logic [ROW_W-1:0]  FULL_ROWS = ROW_W'(NUM_LINES);

    logic [ADDR_W-1:0] col_r;
    logic [ROW_W-1:0]  rows_filled_r;
    logic              len_err_r;
    logic              m_valid_r;
    logic [WIDTH-1:0]  pix_r;
    logic [ADDR_W-1:0] m_col_r;
    logic              m_last_r;
    logic              m_rows_ok_r;
    logic [ROW_W-1:0]  row_tag_r;
    logic              wb_we_r;
    logic [ADDR_W-1:0] wb_addr_r;

    logic              s_ready_s;
    logic              accept_s;
    logic              line_end_s;
    logic [(NUM_LINES+1)*WIDTH-1:0] m_data_s;
    logic [WIDTH-1:0]  bank_dout_s [NUM_LINES];

    // Handshake decode; clr blocks intake so a cleared cycle never shifts the lines.
    always_comb begin
        s_ready_s  = 1'b0;
        accept_s   = 1'b0;
        line_end_s = 1'b0;
        if (clr) begin
            s_ready_s = 1'b0;
        end else begin
            s_ready_s = !m_valid_r || m_ready;
        end
        accept_s   = s_valid && s_ready_s;
        line_end_s = s_last || (col_r == LAST_COL);
    end

    // Column / row-fill counters and the sticky over-length flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r         <= '0;
            rows_filled_r <= '0;
            len_err_r     <= 1'b0;
        end else if (clr) begin
            col_r         <= '0;
            rows_filled_r <= '0;
            len_err_r     <= 1'b0;
        end else if (accept_s) begin
            if (line_end_s) begin
                col_r <= '0;
                if (rows_filled_r != FULL_ROWS) begin
                    rows_filled_r <= rows_filled_r + ROW_W'(1);
                end
                if (!s_last) begin
                    len_err_r <= 1'b1;
                end
            end else begin
                col_r <= col_r + ADDR_W'(1);
            end
        end
    end

    // Write-back stage: the column read on accept is shifted down one bank in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_r   <= 1'b0;
            wb_addr_r <= '0;
        end else begin
            wb_we_r <= accept_s;
            if (accept_s) begin
                wb_addr_r <= col_r;
            end
        end
    end

    // Output register; pix_r doubles as the bank 0 write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r   <= 1'b0;
            pix_r       <= '0;
            m_col_r     <= '0;
            m_last_r    <= 1'b0;
            m_rows_ok_r <= 1'b0;
            row_tag_r   <= '0;
        end else begin
            if (clr) begin
                m_valid_r <= 1'b0;
            end else if (accept_s) begin
                m_valid_r <= 1'b1;
            end else if (m_ready) begin
                m_valid_r <= 1'b0;
            end
            if (accept_s) begin
                pix_r       <= s_data;
                m_col_r     <= col_r;
                m_last_r    <= s_last;
                m_rows_ok_r <= (rows_filled_r == FULL_ROWS);
                row_tag_r   <= rows_filled_r;
            end
        end
    end

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_bank
        logic [WIDTH-1:0] din_s;
        if (k == 0) begin : g_head
            assign din_s = pix_r;
        end else begin : g_tail
            assign din_s = bank_dout_s[k-1];
        end
        lb_dp_ram #(
            .WIDTH  (WIDTH),
            .DEPTH  (LINE_LEN),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (wb_we_r),
            .waddr (wb_addr_r),
            .din   (din_s),
            .re    (accept_s),
            .raddr (col_r),
            .dout  (bank_dout_s[k])
        );
    end

    // Column assembly; rows above the filled region are zero so stale RAM never leaks out.
    always_comb begin
        m_data_s            = '0;
        m_data_s[WIDTH-1:0] = pix_r;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (k < int'(row_tag_r)) begin
                m_data_s[(k+1)*WIDTH +: WIDTH] = bank_dout_s[k];
            end else begin
                m_data_s[(k+1)*WIDTH +: WIDTH] = '0;
            end
        end
    end

    assign s_ready   = s_ready_s;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_s;
    assign m_col     = m_col_r;
    assign m_last    = m_last_r;
    assign m_rows_ok = m_rows_ok_r;
    assign len_err   = len_err_r;

endmodule
